// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory arbiter slice:
//   - MemOp encodings used by the CPU load/store path
//   - arbiter FSM state type (IDLE / RESP_A / RESP_B)
//   - default address of the memory-mapped seven-segment register
//   - owner encoding for the last_owner fairness register
package dmem_pkg;

   localparam logic [2:0] MEMOP_LB  = 3'b000;
   localparam logic [2:0] MEMOP_LH  = 3'b001;
   localparam logic [2:0] MEMOP_LW  = 3'b010;
   localparam logic [2:0] MEMOP_LBU = 3'b100;
   localparam logic [2:0] MEMOP_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RESP_A = 2'd1,
      RESP_B = 2'd2
   } arb_state_t;

   localparam logic [31:0] SEG_ADDR_DEFAULT = 32'h1004F000;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
// Two-way combinational arbiter for the data-memory port.
// Ports:
//   req_a, req_b  : requests from port A (CPU) and port B (debug master)
//   last_owner    : port granted most recently (OWNER_A / OWNER_B)
//   gnt_a, gnt_b  : one-hot-or-zero grants
// Parameter RR_EN selects round-robin tie breaking (1) or fixed A priority (0).
module dmem_arb_pick
   import dmem_pkg::*;
#(
   parameter bit RR_EN = 1'b0
) (
   input  logic req_a,
   input  logic req_b,
   input  logic last_owner,
   output logic gnt_a,
   output logic gnt_b
);

   logic a_wins_tie;

   // On a tie, round-robin hands the grant to whichever port did not own the
   // bus last; fixed priority always favours the CPU.
   always_comb begin
      a_wins_tie = RR_EN ? (last_owner == OWNER_B) : 1'b1;
      gnt_a      = req_a & (~req_b | a_wins_tie);
      gnt_b      = req_b & ~gnt_a;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data RAM port between port A (CPU load/store) and port B
// (debug / program loader), and decodes the seven-segment display register.
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie breaking;
// otherwise port A has fixed priority and no last_owner register exists.
// Ports:
//   CLK, RST                : clock, asynchronous active-high reset
//   a_* / b_*               : requester interfaces (req/we/addr/wdata/op in,
//                             gnt/rvalid/rdata out)
//   mem_en/we/addr/wdata/op : synchronous RAM request, one-cycle read latency
//   mem_rdata               : RAM read data, valid the cycle after a read
//   seg_data                : display register contents
//   busy                    : a read response is being returned this cycle
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter logic [31:0] SEG_ADDR = SEG_ADDR_DEFAULT,
   parameter int          AW       = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [31:0]   a_addr,
   input  logic [31:0]   a_wdata,
   input  logic [2:0]    a_op,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [31:0]   a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [31:0]   b_addr,
   input  logic [31:0]   b_wdata,
   input  logic [2:0]    b_op,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [31:0]   b_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [2:0]    mem_op,
   input  logic [31:0]   mem_rdata,
   output logic [31:0]   seg_data,
   output logic          busy
);

   arb_state_t  state_q, state_d;
   logic        seg_resp_q, seg_resp_d;
   logic        last_owner;
   logic        gnt_a, gnt_b, gnt_any;
   logic        win_we;
   logic [31:0] win_addr, win_wdata;
   logic [2:0]  win_op;
   logic        win_is_seg;
   logic [31:0] resp_data;

   // Requests are masked while reset is held so nothing is granted or
   // issued to memory until the arbiter is released.
   dmem_arb_pick #(
`ifdef DMEM_ARB_RR_EN
      .RR_EN(1'b1)
`else
      .RR_EN(1'b0)
`endif
   ) u_pick (
      .req_a      (a_req & ~RST),
      .req_b      (b_req & ~RST),
      .last_owner (last_owner),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b)
   );

   // Winner mux: the granted port's access fields, plus the MMIO decode.
   always_comb begin
      gnt_any    = gnt_a | gnt_b;
      win_we     = gnt_b ? b_we    : a_we;
      win_addr   = gnt_b ? b_addr  : a_addr;
      win_wdata  = gnt_b ? b_wdata : a_wdata;
      win_op     = gnt_b ? b_op    : a_op;
      win_is_seg = (win_addr == SEG_ADDR);
   end

`ifdef DMEM_ARB_RR_EN
   // Remembers the most recent owner so the next tie goes to the other port.
   // Resets to B so the CPU wins the first tie.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         last_owner <= OWNER_B;
      else if (gnt_any)
         last_owner <= gnt_b ? OWNER_B : OWNER_A;
   end
`else
   assign last_owner = OWNER_B;
`endif

   // State register: which port (if any) receives read data this cycle and
   // whether that data comes from the display register instead of RAM.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         seg_resp_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         seg_resp_q <= seg_resp_d;
      end
   end

   // Next state: any granted read opens a response window for its port next
   // cycle, even while the current response is still being returned.
   always_comb begin
      state_d    = IDLE;
      seg_resp_d = 1'b0;
      if (gnt_any && !win_we) begin
         state_d    = gnt_b ? RESP_B : RESP_A;
         seg_resp_d = win_is_seg;
      end
   end

   // Display register: a granted write to SEG_ADDR always stores the whole
   // word, regardless of the MemOp size.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         seg_data <= 32'h0;
      else if (gnt_any && win_we && win_is_seg)
         seg_data <= win_wdata;
   end

   // Outputs: memory strobe suppressed for MMIO accesses, response data routed
   // only to the port that owns the current response window.
   always_comb begin
      a_gnt     = gnt_a;
      b_gnt     = gnt_b;
      mem_en    = gnt_any & ~win_is_seg;
      mem_we    = gnt_any & win_we & ~win_is_seg;
      mem_addr  = gnt_any ? win_addr[AW-1:0] : '0;
      mem_wdata = gnt_any ? win_wdata : 32'h0;
      mem_op    = gnt_any ? win_op : 3'b000;
      resp_data = seg_resp_q ? seg_data : mem_rdata;
      a_rvalid  = (state_q == RESP_A);
      b_rvalid  = (state_q == RESP_B);
      a_rdata   = a_rvalid ? resp_data : 32'h0;
      b_rdata   = b_rvalid ? resp_data : 32'h0;
      busy      = (state_q != IDLE);
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter with a small word RAM model
// behind the memory port (one-cycle registered read).
module tb_dmem_arbiter;

   logic        CLK;
   logic        RST;
   logic        a_req, a_we, b_req, b_we;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic [2:0]  a_op, b_op;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [31:0] a_rdata, b_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [2:0]  mem_op;
   logic [31:0] seg_data;
   logic        busy;

   logic [31:0] ram [0:16383];

   int checkCount = 0;
   int failCount  = 0;

   dmem_arbiter dut (
      .CLK(CLK), .RST(RST),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_op(a_op),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_op(b_op),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_op(mem_op), .mem_rdata(mem_rdata),
      .seg_data(seg_data), .busy(busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Word-addressed RAM model, write on enable, registered read.
   always @(posedge CLK) begin
      if (mem_en && mem_we)
         ram[mem_addr[15:2]] <= mem_wdata;
      if (mem_en && !mem_we)
         mem_rdata <= ram[mem_addr[15:2]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit portB, input logic req, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (portB) begin
         b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_op = 3'b010;
      end else begin
         a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_op = 3'b010;
      end
   endtask

   initial begin
      mem_rdata = 32'h0;
      ram[8] = 32'hA0A00020;
      ram[9] = 32'hB0B00024;
      RST = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      #12;
      checkOutput("rst_a_gnt", {31'b0, a_gnt}, 32'h0);
      checkOutput("rst_mem_en", {31'b0, mem_en}, 32'h0);
      checkOutput("rst_a_rvalid", {31'b0, a_rvalid}, 32'h0);
      checkOutput("rst_seg", seg_data, 32'h0);
      checkOutput("rst_busy", {31'b0, busy}, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge CLK);
      RST = 1'b0;

      // A writes then reads 0x10
      @(negedge CLK);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      #1;
      checkOutput("wr_a_gnt", {31'b0, a_gnt}, 32'h1);
      checkOutput("wr_mem_en", {31'b0, mem_en}, 32'h1);
      checkOutput("wr_mem_we", {31'b0, mem_we}, 32'h1);
      checkOutput("wr_mem_addr", {16'b0, mem_addr}, 32'h10);
      @(negedge CLK);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      checkOutput("rd_a_gnt", {31'b0, a_gnt}, 32'h1);
      checkOutput("rd_mem_en", {31'b0, mem_en}, 32'h1);
      checkOutput("rd_mem_we", {31'b0, mem_we}, 32'h0);
      @(negedge CLK);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("rd_a_rvalid", {31'b0, a_rvalid}, 32'h1);
      checkOutput("rd_a_rdata", a_rdata, 32'hDEADBEEF);
      checkOutput("rd_busy", {31'b0, busy}, 32'h1);
      checkOutput("rd_b_rvalid", {31'b0, b_rvalid}, 32'h0);
      checkOutput("rd_b_rdata", b_rdata, 32'h0);
      @(negedge CLK);
      checkOutput("idle_busy", {31'b0, busy}, 32'h0);

      // B writes and reads the display register
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h1004F000, 32'h12345678);
      #1;
      checkOutput("seg_wr_b_gnt", {31'b0, b_gnt}, 32'h1);
      checkOutput("seg_wr_mem_en", {31'b0, mem_en}, 32'h0);
      checkOutput("seg_wr_mem_we", {31'b0, mem_we}, 32'h0);
      @(negedge CLK);
      checkOutput("seg_data_wr", seg_data, 32'h12345678);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h1004F000, 32'h0);
      #1;
      checkOutput("seg_rd_b_gnt", {31'b0, b_gnt}, 32'h1);
      checkOutput("seg_rd_mem_en", {31'b0, mem_en}, 32'h0);
      @(negedge CLK);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("seg_rd_b_rvalid", {31'b0, b_rvalid}, 32'h1);
      checkOutput("seg_rd_b_rdata", b_rdata, 32'h12345678);
      checkOutput("seg_rd_a_rvalid", {31'b0, a_rvalid}, 32'h0);

      // Both request reads for six cycles; last owner so far is B
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
         #1;
`ifdef DMEM_ARB_RR_EN
         checkOutput($sformatf("tie_a_gnt%0d", i), {31'b0, a_gnt}, (i % 2 == 0) ? 32'h1 : 32'h0);
         checkOutput($sformatf("tie_b_gnt%0d", i), {31'b0, b_gnt}, (i % 2 == 1) ? 32'h1 : 32'h0);
`else
         checkOutput($sformatf("tie_a_gnt%0d", i), {31'b0, a_gnt}, 32'h1);
         checkOutput($sformatf("tie_b_gnt%0d", i), {31'b0, b_gnt}, 32'h0);
`endif
      end
      @(negedge CLK);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge CLK);

      // Back-to-back A reads of 0x20 and 0x24
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
      #1;
      checkOutput("b2b_gnt0", {31'b0, a_gnt}, 32'h1);
      @(negedge CLK);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h24, 32'h0);
      #1;
      checkOutput("b2b_gnt1", {31'b0, a_gnt}, 32'h1);
      checkOutput("b2b_rvalid0", {31'b0, a_rvalid}, 32'h1);
      checkOutput("b2b_rdata0", a_rdata, 32'hA0A00020);
      checkOutput("b2b_busy0", {31'b0, busy}, 32'h1);
      @(negedge CLK);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("b2b_rvalid1", {31'b0, a_rvalid}, 32'h1);
      checkOutput("b2b_rdata1", a_rdata, 32'hB0B00024);
      checkOutput("b2b_busy1", {31'b0, busy}, 32'h1);
      @(negedge CLK);
      checkOutput("b2b_busy_end", {31'b0, busy}, 32'h0);

      // Address wrap: 0x00010004 aliases to 0x0004
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h00010004, 32'h1);
      #1;
      checkOutput("wrap_mem_en", {31'b0, mem_en}, 32'h1);
      checkOutput("wrap_mem_addr", {16'b0, mem_addr}, 32'h4);
      @(negedge CLK);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("wrap_seg", seg_data, 32'h12345678);
      checkOutput("wrap_ram", ram[1], 32'h1);

      // Reset in the middle of an A read response
      @(negedge CLK);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge CLK);
      #1;
      checkOutput("mid_rvalid_pre", {31'b0, a_rvalid}, 32'h1);
      RST = 1'b1;
      #1;
      checkOutput("mid_rvalid", {31'b0, a_rvalid}, 32'h0);
      checkOutput("mid_seg", seg_data, 32'h0);
      checkOutput("mid_mem_en", {31'b0, mem_en}, 32'h0);
      checkOutput("mid_a_gnt", {31'b0, a_gnt}, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      checkOutput("post_rst_a_gnt", {31'b0, a_gnt}, 32'h1);
      @(negedge CLK);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput("post_rst_rdata", a_rdata, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
